// File: rtl/matrix_mul_ctrl_pkg.sv
// Shared widths and state encoding for the 4x4 fp32 matrix multiply controller.
package matrix_mul_ctrl_pkg;

    localparam int unsigned MAT_DIM = 4;
    localparam int unsigned FP_W    = 32;
    localparam int unsigned ROW_W   = MAT_DIM * FP_W;
    localparam int unsigned MAT_W   = MAT_DIM * ROW_W;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_row_comp.sv
// Combinational 4-term fp32 dot product; denormals flush to zero, results truncate.
import matrix_mul_ctrl_pkg::*;

module matrix_row_comp (
    input  logic [ROW_W-1:0] i_a,
    input  logic [ROW_W-1:0] i_b,
    output logic [FP_W-1:0]  o_result
);

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [22:0] frac;
        logic        sign;
        int          e;
        sign = a[31] ^ b[31];
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = 32'(a[30:23]) + 32'(b[30:23]) - 127;
        if (prod[47]) begin
            frac = prod[46:24];
            e    = e + 1;
        end else begin
            frac = prod[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) return {sign, 31'd0};
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, 8'(e), frac};
    endfunction

    // Larger magnitude operand sets exponent and sign; 3 guard bits, no rounding.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [26:0] mx;
        logic [26:0] my;
        logic [27:0] s;
        int          e;
        int          d;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        e  = 32'(x[30:23]);
        d  = 32'(x[30:23]) - 32'(y[30:23]);
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        my = (d > 26) ? 27'd0 : (my >> d);
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = s >> 1;
                e = e + 1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return 32'd0;
            for (int k = 0; k < 26; k++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        if (e <= 0) return {x[31], 31'd0};
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        return {x[31], 8'(e), s[25:3]};
    endfunction

    logic [FP_W-1:0] w_prod [MAT_DIM];

    always_comb begin
        for (int k = 0; k < MAT_DIM; k++) begin
            w_prod[k] = fp_mul(i_a[FP_W*k +: FP_W], i_b[FP_W*k +: FP_W]);
        end
        o_result = fp_add(fp_add(w_prod[0], w_prod[1]), fp_add(w_prod[2], w_prod[3]));
    end

endmodule

// File: rtl/matrix_mul_ctrl.sv
// Sequences one shared matrix_row_comp over all 16 row/column pairs of C = A x B (or A x B^T).
import matrix_mul_ctrl_pkg::*;

module matrix_mul_ctrl #(
    parameter int unsigned RC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             transp_b,
    input  logic [MAT_W-1:0] mat_a,
    input  logic [MAT_W-1:0] mat_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAT_W-1:0] mat_c,
    output logic             busy
);

    localparam int unsigned CNT_W = (RC_LAT < 1) ? 1 : $clog2(RC_LAT + 1);

    generate
        if (RC_LAT < 1) begin : g_bad_rc_lat
            $error("matrix_mul_ctrl: RC_LAT must be at least 1");
        end
    endgenerate

    // Column j of B packed with B[k][j] in slot k, matching the row layout of A.
    function automatic logic [ROW_W-1:0] col_of(input logic [MAT_W-1:0] m, input logic [1:0] j);
        logic [ROW_W-1:0] col;
        for (int k = 0; k < MAT_DIM; k++) begin
            col[FP_W*k +: FP_W] = m[ROW_W*k + FP_W*32'(j) +: FP_W];
        end
        return col;
    endfunction

    state_e           r_state;
    logic [MAT_W-1:0] r_a;
    logic [MAT_W-1:0] r_b;
    logic             r_transp;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [ROW_W-1:0] r_rc_a;
    logic [ROW_W-1:0] r_rc_b;
    logic [MAT_W-1:0] r_mat_c;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [FP_W-1:0]  w_rc_result;
    logic [1:0]       w_i;
    logic [1:0]       w_j;

    assign w_i = r_idx[3:2];
    assign w_j = r_idx[1:0];

    matrix_row_comp u_row_comp (
        .i_a      (r_rc_a),
        .i_b      (r_rc_b),
        .o_result (w_rc_result)
    );

    // Each element: load operands (cnt 0), hold RC_LAT cycles, capture on cnt == RC_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_transp    <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rc_a      <= '0;
            r_rc_b      <= '0;
            r_mat_c     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= mat_a;
                        r_b        <= mat_b;
                        r_transp   <= transp_b;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_COMP;
                    end
                end
                ST_COMP: begin
                    if (r_cnt == '0) begin
                        r_rc_a <= r_a[ROW_W*32'(w_i) +: ROW_W];
                        r_rc_b <= r_transp ? r_b[ROW_W*32'(w_j) +: ROW_W] : col_of(r_b, w_j);
                        r_cnt  <= CNT_W'(1);
                    end else if (r_cnt == CNT_W'(RC_LAT)) begin
                        r_mat_c[FP_W*32'(r_idx) +: FP_W] <= w_rc_result;
                        r_cnt <= '0;
                        if (r_idx == IDX_W'(15)) begin
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign mat_c     = r_mat_c;
    assign busy      = r_busy;

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// Directed bench for matrix_mul_ctrl: expected C matrices queued at issue, compared at output.
module tb_matrix_mul_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_valid2;
    logic         in_ready, in_ready2;
    logic         transp_b;
    logic [511:0] mat_a, mat_b;
    logic         out_valid, out_valid2;
    logic         out_ready, out_ready2;
    logic [511:0] mat_c, mat_c2;
    logic         busy, busy2;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [511:0] exp_q [$];

    always #5 clk = ~clk;

    matrix_mul_ctrl #(.RC_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .transp_b(transp_b),
        .mat_a(mat_a), .mat_b(mat_b), .out_valid(out_valid), .out_ready(out_ready),
        .mat_c(mat_c), .busy(busy)
    );

    matrix_mul_ctrl #(.RC_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .transp_b(transp_b),
        .mat_a(mat_a), .mat_b(mat_b), .out_valid(out_valid2), .out_ready(out_ready2),
        .mat_c(mat_c2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Exact fp32 encoding of a small non-negative integer.
    function automatic logic [31:0] fp_of(input int n);
        int p;
        logic [31:0] v;
        if (n == 0) return 32'd0;
        p = 0;
        for (int b = 0; b < 31; b++) if ((n >> b) != 0) p = b;
        v = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), v[22:0]};
    endfunction

    function automatic logic [511:0] ident(input logic [31:0] v);
        logic [511:0] m = '0;
        for (int i = 0; i < 4; i++) m[32*(4*i+i) +: 32] = v;
        return m;
    endfunction

    function automatic logic [511:0] fill(input logic [31:0] v);
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[32*k +: 32] = v;
        return m;
    endfunction

    task automatic send(input logic [511:0] a, input logic [511:0] b, input logic t);
        int n = 0;
        mat_a = a; mat_b = b; transp_b = t; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) check("send_timeout", 512'(in_ready), 512'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!out_valid) check({tag, "_timeout"}, 512'(out_valid), 512'(1));
    endtask

    task automatic pop_check(input string tag, input logic [511:0] obs);
        if (exp_q.size() == 0) check({tag, "_empty"}, 512'(0), 512'(1));
        else check(tag, obs, exp_q.pop_front());
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_in_ready"}, 512'(in_ready), 512'(1));
        check({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    endtask

    logic [511:0] b1, upper, lower, b7, c7, e;
    int lat, lat2;

    initial begin
        rst = 1'b1; in_valid = 0; in_valid2 = 0; out_ready = 0; out_ready2 = 0;
        transp_b = 0; mat_a = '0; mat_b = '0;
        for (int k = 0; k < 16; k++) b1[32*k +: 32] = fp_of(2 * (k + 1));
        upper = '0; lower = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (j >= i) upper[32*(4*i+j) +: 32] = 32'h3F80_0000;
                if (j <= i) lower[32*(4*i+j) +: 32] = 32'h3F80_0000;
                b7[32*(4*i+j) +: 32] = fp_of(4 * i + j + 1);
                c7[32*(4*i+j) +: 32] = fp_of(28 + 4 * j);
            end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(1));
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_mat_c", mat_c, '0);

        // Identity A: C equals B; both latencies measured on one accept.
        exp_q.push_back(b1);
        mat_a = ident(32'h3F80_0000); mat_b = b1; transp_b = 1'b0;
        in_valid = 1'b1; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_valid2 = 1'b0;
        check("t1_busy", 512'(busy), 512'(1));
        lat = 0; lat2 = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (out_valid && lat == 0) lat = n;
            if (out_valid2 && lat2 == 0) lat2 = n;
        end
        check("t1_lat_rc1", 512'(lat), 512'(32));
        check("t1_lat_rc2", 512'(lat2), 512'(48));
        check("t1_mat_c_rc2", mat_c2, b1);
        pop_check("t1_mat_c", mat_c);
        out_ready2 = 1'b1;
        handshake("t1");
        out_ready2 = 1'b0;
        check("t1_out_valid2", 512'(out_valid2), 512'(0));

        // 2I x ones.
        exp_q.push_back(fill(32'h4000_0000));
        send(ident(32'h4000_0000), fill(32'h3F80_0000), 1'b0);
        wait_out("t2", lat);
        pop_check("t2_mat_c", mat_c);
        handshake("t2");

        // Transposed B path: I x U^T = lower-triangular ones.
        exp_q.push_back(lower);
        send(ident(32'h3F80_0000), upper, 1'b1);
        wait_out("t3", lat);
        check("t3_lat", 512'(lat), 512'(32));
        pop_check("t3_mat_c", mat_c);
        handshake("t3");

        // Ones x integer pattern exercises the adder and column gather.
        exp_q.push_back(c7);
        send(fill(32'h3F80_0000), b7, 1'b0);
        wait_out("t7", lat);
        pop_check("t7_mat_c", mat_c);
        handshake("t7");

        // Output back-pressure: result held, input ignored.
        e = c7;
        exp_q.push_back(e);
        send(fill(32'h3F80_0000), b7, 1'b0);
        wait_out("t4", lat);
        pop_check("t4_mat_c", mat_c);
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0]; mat_a = fill(32'h4000_0000); mat_b = upper;
            @(negedge clk);
            check("t4_hold_mat_c", mat_c, e);
            check("t4_hold_in_ready", 512'(in_ready), 512'(0));
            check("t4_hold_out_valid", 512'(out_valid), 512'(1));
        end
        in_valid = 1'b0;
        handshake("t4");
        @(negedge clk);
        check("t4_no_accept", 512'(busy), 512'(0));

        // Reset mid-computation, then a clean job.
        send(ident(32'h3F80_0000), b1, 1'b0);
        repeat (9) @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("t5_out_valid", 512'(out_valid), 512'(0));
        check("t5_in_ready", 512'(in_ready), 512'(1));
        check("t5_busy", 512'(busy), 512'(0));
        check("t5_mat_c", mat_c, '0);
        exp_q.push_back(lower);
        send(ident(32'h3F80_0000), upper, 1'b1);
        wait_out("t5", lat);
        pop_check("t5_mat_c_after", mat_c);
        handshake("t5");

        // Back-to-back with in_valid held; inputs change mid-job to the second job's data.
        exp_q.push_back(fill(32'h4000_0000));
        exp_q.push_back(c7);
        mat_a = ident(32'h4000_0000); mat_b = fill(32'h3F80_0000); transp_b = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        mat_a = fill(32'h3F80_0000); mat_b = b7;
        wait_out("t6a", lat);
        check("t6a_lat", 512'(lat), 512'(32));
        pop_check("t6a_mat_c", mat_c);
        @(negedge clk);
        check("t6_gap_in_ready", 512'(in_ready), 512'(1));
        check("t6_gap_out_valid", 512'(out_valid), 512'(0));
        @(negedge clk);
        check("t6_second_accept", 512'(busy), 512'(1));
        in_valid = 1'b0;
        wait_out("t6b", lat);
        check("t6b_lat", 512'(lat), 512'(32));
        pop_check("t6b_mat_c", mat_c);
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_end_out_valid", 512'(out_valid), 512'(0));
        check("t6_end_in_ready", 512'(in_ready), 512'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
